// File: rtl/linear_interp_if.sv
// Sample-stream bundle between the TX sample FIFO side and the interpolator.
// The master drives rate/tick/data; the slave returns the fetch request and the high-rate output.
interface linear_interp_if #(
  parameter int unsigned data_width = 12,
  parameter int unsigned rate_width = 4
);
  logic                         enable;
  logic [rate_width-1:0]        log2rate;
  logic                         strobe_in;
  logic signed [data_width-1:0] data_in;
  logic                         sample_req;
  logic                         strobe_out;
  logic signed [data_width-1:0] data_out;

  modport master (
    output enable, log2rate, strobe_in, data_in,
    input  sample_req, strobe_out, data_out
  );

  modport slave (
    input  enable, log2rate, strobe_in, data_in,
    output sample_req, strobe_out, data_out
  );
endinterface

// File: rtl/linear_interp.sv
// Power-of-two linear interpolator: fetches one sample every 2^log2rate output ticks
// and emits a floor-rounded linear ramp from the previous sample to the current one.
module linear_interp #(
  parameter int unsigned data_width = 12,
  parameter int unsigned rate_width = 4,
  parameter int unsigned max_log2   = 8
) (
  input  logic          clock,
  input  logic          reset,
  linear_interp_if.slave bus
);
  localparam int unsigned acc_width = data_width + max_log2 + 1;
  localparam int unsigned dlt_width = data_width + 1;
  localparam int unsigned cnt_width = (max_log2 > 0) ? max_log2 : 1;

  logic [rate_width-1:0]         log2rate;
  logic [cnt_width-1:0]          count_q, count_d;
  logic signed [data_width-1:0]  prev_q, prev_d;
  logic signed [data_width-1:0]  curr_q, curr_d;
  logic signed [data_width-1:0]  data_out_q, data_out_d;
  logic signed [acc_width-1:0]   acc_q, acc_d;
  logic                          strobe_out_q, strobe_out_d;
  logic signed [dlt_width-1:0]   delta;
  logic signed [acc_width-1:0]   acc_step;
  logic signed [acc_width-1:0]   curr_ext;
  logic                          fetch_c;

  assign log2rate = bus.log2rate;
  assign delta    = dlt_width'(curr_q) - dlt_width'(prev_q);
  assign acc_step = acc_q + acc_width'(delta);
  assign curr_ext = acc_width'(curr_q);

  // Fetch happens on the first tick of each input period; no other qualifier.
  assign fetch_c        = bus.enable & ~reset & bus.strobe_in & (count_q == '0);
  assign bus.sample_req = fetch_c;
  assign bus.strobe_out = strobe_out_q;
  assign bus.data_out   = data_out_q;

  always_comb begin
    count_d      = count_q;
    prev_d       = prev_q;
    curr_d       = curr_q;
    acc_d        = acc_q;
    data_out_d   = data_out_q;
    strobe_out_d = 1'b0;
    if (!bus.enable) begin
      // Flush to the idle state; data_out deliberately keeps its last value.
      count_d = '0;
      prev_d  = '0;
      curr_d  = '0;
      acc_d   = '0;
    end else if (bus.strobe_in) begin
      strobe_out_d = 1'b1;
      if (count_q == '0) begin
        prev_d     = curr_q;
        curr_d     = bus.data_in;
        acc_d      = curr_ext <<< log2rate;
        data_out_d = curr_q;
        count_d    = ~({cnt_width{1'b1}} << log2rate);
      end else begin
        acc_d      = acc_step;
        data_out_d = data_width'(acc_step >>> log2rate);
        count_d    = count_q - cnt_width'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      prev_q       <= '0;
      curr_q       <= '0;
      acc_q        <= '0;
      data_out_q   <= '0;
      strobe_out_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      prev_q       <= prev_d;
      curr_q       <= curr_d;
      acc_q        <= acc_d;
      data_out_q   <= data_out_d;
      strobe_out_q <= strobe_out_d;
    end
  end
endmodule
